// File: rtl/uart_rcv_pkg.sv
// Shared types, legal parameter ranges and the parity helper for the UART receiver.
// Macro UART_RCV_PARITY_EN adds the PARITY state to the receiver FSM.
package uart_rcv_pkg;

    localparam int unsigned DATA_BITS_MIN    = 5;
    localparam int unsigned DATA_BITS_MAX    = 9;
    localparam int unsigned CLKS_PER_BIT_MIN = 4;
    localparam int unsigned BIT_CNT_W        = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RCV_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_STORE  = 3'd5
    } rcv_state_e;

    // Expected parity bit; unused upper bits must be passed as zero.
    function automatic logic calc_parity(input logic [DATA_BITS_MAX-1:0] data,
                                         input logic odd);
        calc_parity = (^data) ^ odd;
    endfunction

endpackage

// File: rtl/rcv_fifo.sv
// Show-ahead receive FIFO with occupancy count and sticky overrun flag.
module rcv_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       not_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overrun
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] head_r;
    logic             ready_r;
    logic             overrun_r;

    logic             full_s;
    logic             do_pop_s;
    logic             do_push_s;
    logic             ovr_set_s;
    logic [CW-1:0]    count_next_s;
    logic [PW-1:0]    rd_next_s;
    logic [WIDTH-1:0] head_next_s;

    // Push/pop qualification; a full FIFO still accepts a push paired with a pop.
    always_comb begin
        full_s       = (count_r == CW'(DEPTH));
        do_pop_s     = pop && (count_r != {CW{1'b0}});
        do_push_s    = push && (!full_s || do_pop_s);
        ovr_set_s    = push && full_s && !do_pop_s;
        count_next_s = count_r;
        if (do_push_s && !do_pop_s) begin
            count_next_s = count_r + CW'(1'b1);
        end else if (!do_push_s && do_pop_s) begin
            count_next_s = count_r - CW'(1'b1);
        end else begin
            count_next_s = count_r;
        end
        if (do_pop_s) begin
            rd_next_s = rd_ptr_r + PW'(1'b1);
        end else begin
            rd_next_s = rd_ptr_r;
        end
        if (do_push_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = push_data;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Storage, pointers, count and registered head/ready/overrun.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
            head_r    <= {WIDTH{1'b0}};
            ready_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
            end
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            head_r   <= head_next_s;
            ready_r  <= (count_next_s != {CW{1'b0}});
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (do_pop_s) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign head      = head_r;
    assign not_empty = ready_r;
    assign count     = count_r;
    assign overrun   = overrun_r;

endmodule

// File: rtl/uart_rcv_fifo.sv
// UART receiver: synchroniser, bit timing, frame FSM and error flags feeding rcv_fifo.
// Define UART_RCV_PARITY_EN to add a parity bit and parity check after the data bits.
module uart_rcv_fifo #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            serial_in,
    input  logic                            data_read,
    output logic [DATA_BITS-1:0]            rx_data,
    output logic                            data_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overrun_error,
    output logic                            framing_error,
    output logic                            parity_error
);

    import uart_rcv_pkg::*;

    localparam int CCW = $clog2(CLKS_PER_BIT);

    logic                 sync1_r;
    logic                 sync2_r;
    logic                 prev_r;
    logic [1:0]           fill_r;
    logic                 armed_r;
    rcv_state_e           state_r;
    rcv_state_e           next_state_s;
    logic [CCW-1:0]       clk_cnt_r;
    logic [BIT_CNT_W-1:0] bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 framing_r;
    logic                 fall_s;
    logic                 half_done_s;
    logic                 bit_done_s;
    logic                 last_bit_s;
    logic                 sample_s;
    logic                 start_s;
    logic                 push_s;
    logic                 frame_bad_s;

    // Two-flop synchroniser; armed_r blocks a false edge when reset releases mid-frame.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
            fill_r  <= 2'b00;
            armed_r <= 1'b0;
        end else begin
            sync1_r <= serial_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            fill_r  <= {fill_r[0], 1'b1};
            armed_r <= armed_r | (fill_r[1] & sync2_r);
        end
    end

    assign fall_s      = armed_r && prev_r && !sync2_r;
    assign half_done_s = (clk_cnt_r == CCW'(CLKS_PER_BIT / 2 - 1));
    assign bit_done_s  = (clk_cnt_r == CCW'(CLKS_PER_BIT - 1));
    assign last_bit_s  = (bit_cnt_r == BIT_CNT_W'(DATA_BITS - 1));

    // Frame state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic with the per-state line-sample strobe.
    always_comb begin
        next_state_s = state_r;
        sample_s     = 1'b0;
        start_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    next_state_s = ST_START;
                    start_s      = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (half_done_s) begin
                    sample_s     = 1'b1;
                    next_state_s = sync2_r ? ST_IDLE : ST_DATA;
                end else begin
                    next_state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    sample_s = 1'b1;
                    if (last_bit_s) begin
`ifdef UART_RCV_PARITY_EN
                        next_state_s = ST_PARITY;
`else
                        next_state_s = ST_STOP;
`endif
                    end else begin
                        next_state_s = ST_DATA;
                    end
                end else begin
                    next_state_s = ST_DATA;
                end
            end
`ifdef UART_RCV_PARITY_EN
            ST_PARITY: begin
                if (bit_done_s) begin
                    sample_s     = 1'b1;
                    next_state_s = ST_STOP;
                end else begin
                    next_state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done_s) begin
                    sample_s     = 1'b1;
                    next_state_s = ST_STORE;
                end else begin
                    next_state_s = ST_STOP;
                end
            end
            ST_STORE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Bit-period timer, data bit counter and LSB-first shift register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            clk_cnt_r <= {CCW{1'b0}};
            bit_cnt_r <= {BIT_CNT_W{1'b0}};
            shift_r   <= {DATA_BITS{1'b0}};
        end else begin
            if ((state_r == ST_IDLE) || sample_s) begin
                clk_cnt_r <= {CCW{1'b0}};
            end else begin
                clk_cnt_r <= clk_cnt_r + CCW'(1'b1);
            end
            if (state_r == ST_IDLE) begin
                bit_cnt_r <= {BIT_CNT_W{1'b0}};
            end else if ((state_r == ST_DATA) && sample_s) begin
                bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1'b1);
                shift_r   <= {sync2_r, shift_r[DATA_BITS-1:1]};
            end
        end
    end

    // Framing flag: cleared when a new frame starts, set by a low stop bit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            framing_r <= 1'b0;
        end else if (start_s) begin
            framing_r <= 1'b0;
        end else if ((state_r == ST_STOP) && sample_s && !sync2_r) begin
            framing_r <= 1'b1;
        end
    end

`ifdef UART_RCV_PARITY_EN
    logic parity_r;

    // Parity flag, same lifetime as the framing flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parity_r <= 1'b0;
        end else if (start_s) begin
            parity_r <= 1'b0;
        end else if ((state_r == ST_PARITY) && sample_s) begin
            parity_r <= (sync2_r != calc_parity(DATA_BITS_MAX'(shift_r), (PARITY_ODD != 0)));
        end
    end

    assign frame_bad_s  = framing_r | parity_r;
    assign parity_error = parity_r;
`else
    assign frame_bad_s  = framing_r;
    assign parity_error = 1'b0;
`endif

    assign push_s        = (state_r == ST_STORE) && !frame_bad_s;
    assign framing_error = framing_r;

    rcv_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (push_s),
        .push_data (shift_r),
        .pop       (data_read),
        .head      (rx_data),
        .not_empty (data_ready),
        .count     (fifo_count),
        .overrun   (overrun_error)
    );

endmodule

// File: tb/tb_uart_rcv_fifo.sv
// Self-checking bench for uart_rcv_fifo with a queue-based reference model.
module tb_uart_rcv_fifo;

    localparam int CPB   = 10;
    localparam int DEPTH = 4;
`ifdef UART_RCV_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       serial_in = 1'b1;
    logic       data_read = 1'b0;
    logic [7:0] rx_data;
    logic       data_ready;
    logic [2:0] fifo_count;
    logic       overrun_error;
    logic       framing_error;
    logic       parity_error;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] mq[$];
    bit         m_ovr = 1'b0;
    bit         m_frm = 1'b0;
    bit         m_par = 1'b0;
    logic [6:0] obs;

    always #5 clk = ~clk;

    assign obs = {data_ready, fifo_count, overrun_error, framing_error, parity_error};

    uart_rcv_fifo #(
        .DATA_BITS    (8),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .PARITY_ODD   (0)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .fifo_count    (fifo_count),
        .overrun_error (overrun_error),
        .framing_error (framing_error),
        .parity_error  (parity_error)
    );

    function automatic logic [6:0] exp_status();
        exp_status = {(mq.size() != 0), 3'(mq.size()), m_ovr, m_frm, m_par};
    endfunction

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_flip,
                              input bit stop_bit, input bit mid_chk);
        drive_bit(1'b0);
        if (mid_chk) begin
            vec_cnt++;
            if ({framing_error, parity_error} !== 2'b00) begin
                err_cnt++;
                $display("FAIL start_clear: flags=%b required 00", {framing_error, parity_error});
            end
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit((^d) ^ par_flip);
        drive_bit(stop_bit);
        serial_in = 1'b1;
        m_frm = !stop_bit;
        m_par = PAR_EN && par_flip;
        if (!m_frm && !m_par) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ovr = 1'b1;
        end
        repeat (CPB) @(negedge clk);
    endtask

    task automatic do_read(input string tag);
        if (mq.size() != 0) begin
            vec_cnt++;
            if (rx_data !== mq[0]) begin
                err_cnt++;
                $display("FAIL %s_data: rx_data=%h required %h", tag, rx_data, mq[0]);
            end
        end
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
        if (mq.size() != 0) begin
            void'(mq.pop_front());
            m_ovr = 1'b0;
        end
        @(negedge clk);
        vec_cnt++;
        if (obs !== exp_status()) begin
            err_cnt++;
            $display("FAIL %s_status: got=%b required %b", tag, obs, exp_status());
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({obs, rx_data} !== 15'd0) begin
            err_cnt++;
            $display("FAIL reset_in: status=%b rx=%h required all zero", obs, rx_data);
        end
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        vec_cnt++;
        if (obs !== 7'd0) begin
            err_cnt++;
            $display("FAIL reset_out: status=%b required 0", obs);
        end
    endtask

    task automatic test_good_frame();
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        vec_cnt++;
        if ((obs !== exp_status()) || (obs !== 7'b1_001_000) || (rx_data !== 8'hA5)) begin
            err_cnt++;
            $display("FAIL good_frame: status=%b rx=%h required %b a5", obs, rx_data, exp_status());
        end
        do_read("good_read");
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        vec_cnt++;
        if ((obs !== exp_status()) || (framing_error !== 1'b1)) begin
            err_cnt++;
            $display("FAIL framing_set: status=%b required %b", obs, exp_status());
        end
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        vec_cnt++;
        if (obs !== exp_status()) begin
            err_cnt++;
            $display("FAIL framing_next: status=%b required %b", obs, exp_status());
        end
        do_read("framing_read");
    endtask

    task automatic test_parity();
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        vec_cnt++;
        if (obs !== exp_status()) begin
            err_cnt++;
            $display("FAIL parity: status=%b required %b", obs, exp_status());
        end
        while (mq.size() != 0) do_read("parity_drain");
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 5; i++) begin
            send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 1'b0);
            vec_cnt++;
            if (obs !== exp_status()) begin
                err_cnt++;
                $display("FAIL overrun_fill%0d: status=%b required %b", i, obs, exp_status());
            end
        end
        vec_cnt++;
        if ((fifo_count !== 3'd4) || (overrun_error !== 1'b1)) begin
            err_cnt++;
            $display("FAIL overrun_full: count=%0d ovr=%b required 4 1", fifo_count, overrun_error);
        end
        for (int i = 0; i < 4; i++) do_read("overrun_read");
    endtask

    task automatic test_empty_read();
        do_read("empty_read");
        do_read("empty_read2");
    endtask

    task automatic test_false_start();
        serial_in = 1'b0;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        m_frm = 1'b0;
        m_par = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        vec_cnt++;
        if (obs !== exp_status()) begin
            err_cnt++;
            $display("FAIL false_start: status=%b required %b", obs, exp_status());
        end
        send_frame(8'h7E, 1'b0, 1'b1, 1'b0);
        do_read("false_start_next");
    endtask

    task automatic test_reset_midframe();
        logic [7:0] partial;
        partial = 8'h55;
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(partial[i]);
        serial_in = 1'b0;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({obs, rx_data} !== 15'd0) begin
            err_cnt++;
            $display("FAIL midframe_rst: status=%b rx=%h required all zero", obs, rx_data);
        end
        n_rst = 1'b1;
        mq.delete();
        m_ovr = 1'b0;
        m_frm = 1'b0;
        m_par = 1'b0;
        repeat (20) @(negedge clk);
        serial_in = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_frame(8'h66, 1'b0, 1'b1, 1'b0);
        vec_cnt++;
        if ((obs !== exp_status()) || (fifo_count !== 3'd1) || (rx_data !== 8'h66)) begin
            err_cnt++;
            $display("FAIL midframe_next: status=%b rx=%h required %b 66", obs, rx_data, exp_status());
        end
        do_read("midframe_read");
    endtask

    task automatic test_random();
        logic [7:0] d;
        int         r;
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            r = $urandom_range(0, 7);
            send_frame(d, (r == 1), (r != 0), 1'b1);
            vec_cnt++;
            if (obs !== exp_status()) begin
                err_cnt++;
                $display("FAIL random%0d: status=%b required %b", n, obs, exp_status());
            end
            if ($urandom_range(0, 2) == 0) do_read("random_read");
        end
        while (mq.size() != 0) do_read("random_drain");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_framing();
        test_parity();
        test_overrun();
        test_empty_read();
        test_false_start();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rcv_fifo.md
UART_RCV_FIFO -- requirements
Module: uart_rcv_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 10, meaning clk cycles per bit period; must be even and >= 4.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning received-word buffer depth; must be a power of 2 and >= 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity; used only when the parity macro is defined.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 n_rst  input  1  asynchronous active-low reset.
REQ-007 serial_in  input  1  asynchronous serial line; idles high.
REQ-008 data_read  input  1  one-cycle pop request for the FIFO head.
REQ-009 rx_data  output  DATA_BITS  FIFO head word (show-ahead); valid while data_ready = 1.
REQ-010 data_ready  output  1  FIFO non-empty.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH+1)  number of stored words.
REQ-012 overrun_error  output  1  sticky; a frame was dropped because the FIFO was full.
REQ-013 framing_error  output  1  sticky; last frame had a low stop bit.
REQ-014 parity_error  output  1  sticky; last frame failed the parity check.

Function
REQ-015 serial_in SHALL pass through a 2-flop synchroniser; all detection SHALL use the synchronised value.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, STORE.
REQ-017 IDLE -> START SHALL occur on a synchronised 1->0 transition; the bit counter and cycle counter SHALL clear on entry to START.
REQ-018 START SHALL sample the line CLKS_PER_BIT/2 cycles after entry; high -> IDLE (false start, no flags); low -> DATA.
REQ-019 DATA SHALL sample every CLKS_PER_BIT cycles, shifting LSB-first, and SHALL leave after DATA_BITS samples, to PARITY (macro defined) or STOP.
REQ-020 PARITY SHALL sample one bit CLKS_PER_BIT cycles later and compare it with the XOR of the data bits (XNOR when PARITY_ODD = 1).
REQ-021 STOP SHALL sample CLKS_PER_BIT cycles later; low -> framing_error = 1.
REQ-022 STORE SHALL last exactly one cycle, push the word only if neither framing nor parity error occurred in this frame, then return to IDLE.
REQ-023 data_ready and fifo_count SHALL update on the cycle after STORE.
REQ-024 framing_error and parity_error SHALL clear on entry to START and hold until then.
REQ-025 A push with the FIFO full and no data_read in the same cycle SHALL drop the word and set overrun_error; FIFO contents SHALL be unchanged.
REQ-026 A push and a data_read in the same cycle with the FIFO full SHALL perform both, with no overrun.
REQ-027 overrun_error SHALL clear on any data_read when the FIFO is non-empty.
REQ-028 data_read while the FIFO is empty SHALL be ignored.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL saturate at neither 0 nor FIFO_DEPTH by wrap.

Reset
REQ-030 n_rst low SHALL asynchronously force IDLE, an empty FIFO, rx_data = 0, data_ready = 0, fifo_count = 0, and all error flags = 0, and set the synchroniser flops to 1.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; after release, the receiver SHALL wait for a fresh falling edge.

Configuration
REQ-032 Macro UART_RCV_PARITY_EN defined: the PARITY state and the check SHALL be present.
REQ-033 Macro UART_RCV_PARITY_EN undefined: the PARITY state SHALL be absent (DATA -> STOP) and parity_error SHALL be tied to 0.

Structure
REQ-034 Package uart_rcv_pkg SHALL hold the state enum and the legal-range constants for DATA_BITS and CLKS_PER_BIT.
REQ-035 Sub-module rcv_fifo SHALL implement the parametrised FIFO, count and overrun logic; the top SHALL hold the synchroniser, timing counters, shift register and FSM.

Verification (DATA_BITS = 8, CLKS_PER_BIT = 10, FIFO_DEPTH = 4, macro on, even parity)
REQ-036 Send 0xA5, parity 0, stop 1 -> rx_data = 0xA5, data_ready = 1, fifo_count = 1, no flags.
REQ-037 Send 0x3C with stop 0 -> framing_error = 1, fifo_count unchanged; the next good frame clears framing_error at its START.
REQ-038 Send 0x01 with parity 0 -> parity_error = 1, word not stored.
REQ-039 Send 5 frames 0x10..0x14 with no reads -> fifo_count = 4, overrun_error = 1; reads return 0x10..0x13; the first read clears overrun_error.
REQ-040 Pulse serial_in low for 3 cycles -> FSM returns to IDLE, no push, no flags.
REQ-041 Assert n_rst after bit 4 of frame 0x55, then send 0x66 -> only 0x66 is stored, fifo_count = 1.
